// File: rtl/usb_tx_encoder.sv
// USB low-level transmit encoder: NRZI line coding, optional bit stuffing, EOP generation.
// Bit stuffing is built only when USB_TX_BITSTUFF_EN is defined.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic serial_in,
    input  logic last_byte,
    output logic shift_enable,
    output logic byte_req,
    output logic dplus_out,
    output logic dminus_out,
    output logic tx_busy,
    output logic tx_done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_BITSTUFF_EN
    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, EOP_SE0, EOP_J} state_t;
`endif

    state_t        r_state, w_state;
    logic [TW-1:0] r_timer, w_timer;
    logic [2:0]    r_bitcnt, w_bitcnt;
    logic          r_level, w_level;
    logic          r_dp, r_dm, w_dp, w_dm;
    logic          w_end;
`ifdef USB_TX_BITSTUFF_EN
    logic [2:0]    r_ones, w_ones, w_ones_inc;
    logic          r_eop_pend, w_eop_pend;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_level  <= 1'b1;
            r_dp     <= 1'b1;
            r_dm     <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
            r_ones     <= '0;
            r_eop_pend <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_bitcnt <= w_bitcnt;
            r_level  <= w_level;
            r_dp     <= w_dp;
            r_dm     <= w_dm;
`ifdef USB_TX_BITSTUFF_EN
            r_ones     <= w_ones;
            r_eop_pend <= w_eop_pend;
`endif
        end
    end

    always_comb begin
        w_state      = r_state;
        w_end        = (r_timer == T_LAST);
        w_timer      = w_end ? '0 : r_timer + 1'b1;
        w_bitcnt     = r_bitcnt;
        w_level      = r_level;
        w_dp         = 1'b1;
        w_dm         = 1'b0;
        shift_enable = 1'b0;
        byte_req     = 1'b0;
        tx_done      = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
        w_ones     = r_ones;
        w_eop_pend = r_eop_pend;
        w_ones_inc = serial_in ? r_ones + 3'd1 : 3'd0;
`endif
        case (r_state)
            IDLE: begin
                w_timer = '0;
                if (tx_start) begin
                    w_state  = SEND;
                    w_bitcnt = '0;
                    w_level  = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
                    w_ones     = '0;
                    w_eop_pend = 1'b0;
`endif
                end
            end
            SEND: begin
                // The new line level is chosen in the first clock of the period;
                // the output register makes it visible one clock later.
                if (r_timer == '0) w_level = serial_in ? r_level : ~r_level;
                w_dp = w_level;
                w_dm = ~w_level;
                if (w_end) begin
                    if (r_bitcnt != 3'd7) begin
                        shift_enable = 1'b1;
                        w_bitcnt     = r_bitcnt + 3'd1;
                    end else begin
                        w_bitcnt = '0;
                        byte_req = ~last_byte;
                    end
`ifdef USB_TX_BITSTUFF_EN
                    w_ones = w_ones_inc;
                    if (r_bitcnt == 3'd7) w_eop_pend = last_byte;
                    if (w_ones_inc == 3'd6) begin
                        w_state = STUFF;
                        w_ones  = '0;
                    end else if (r_bitcnt == 3'd7 && last_byte) begin
                        w_state = EOP_SE0;
                    end
`else
                    if (r_bitcnt == 3'd7 && last_byte) w_state = EOP_SE0;
`endif
                end
            end
`ifdef USB_TX_BITSTUFF_EN
            STUFF: begin
                if (r_timer == '0) w_level = ~r_level;
                w_dp = w_level;
                w_dm = ~w_level;
                if (w_end) w_state = r_eop_pend ? EOP_SE0 : SEND;
            end
`endif
            EOP_SE0: begin
                // bit counter is reused to time the two SE0 periods
                w_dp = 1'b0;
                w_dm = 1'b0;
                if (w_end) begin
                    if (r_bitcnt == 3'd1) begin
                        w_state  = EOP_J;
                        w_bitcnt = '0;
                    end else begin
                        w_bitcnt = 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (w_end) begin
                    tx_done = 1'b1;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign dplus_out  = r_dp;
    assign dminus_out = r_dm;
    assign tx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: a packet-level model predicts every output per clock.
module tb_usb_tx_encoder;
    localparam int CPB = 8;
`ifdef USB_TX_BITSTUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst, tx_start, serial_in, last_byte;
    logic shift_enable, byte_req, dplus_out, dminus_out, tx_busy, tx_done;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .serial_in(serial_in),
        .last_byte(last_byte), .shift_enable(shift_enable), .byte_req(byte_req),
        .dplus_out(dplus_out), .dminus_out(dminus_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dp, dm, se, br, dn, busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc_no = 0;
    int   se_cnt = 0, br_cnt = 0, busy_cnt = 0;

    // upstream parallel-to-serial stage
    logic [7:0] pkt[8];
    int         pkt_len = 1;
    int         cur = 0;
    logic [7:0] shreg = 8'h00;
    logic       start_load = 1'b0;

    assign serial_in = shreg[0];
    assign last_byte = (cur == pkt_len - 1);

    always @(posedge clk) begin
        if (start_load) begin
            cur   <= 0;
            shreg <= pkt[0];
        end else if (byte_req) begin
            cur   <= cur + 1;
            shreg <= (cur + 1 < 8) ? pkt[cur+1] : 8'h00;
        end else if (shift_enable) begin
            shreg <= shreg >> 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: one prediction per clock while a packet is outstanding
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e, a;
            e = sb.pop_front();
            a = {dplus_out, dminus_out, shift_enable, byte_req, tx_done, tx_busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d {dp,dm,se,br,done,busy}: got %b expected %b", cyc_no, a, e);
            end
            cyc_no++;
            if (shift_enable) se_cnt++;
            if (byte_req) br_cnt++;
            if (tx_busy) busy_cnt++;
        end
    end

    // Reference: bit sequence with stuffing -> NRZI levels -> per-clock outputs.
    // Line codes: 0 = J, 1 = K, 2 = SE0. Events: 1 shift, 2 byte request, 3 done.
    task automatic build_exp();
        int bits[$], ev[$], line[$];
        int ones = 0, lvl = 0;
        for (int b = 0; b < pkt_len; b++) begin
            for (int j = 0; j < 8; j++) begin
                int bt;
                bt = (pkt[b] >> j) & 1;
                bits.push_back(bt);
                ev.push_back(j < 7 ? 1 : (b == pkt_len - 1 ? 0 : 2));
                ones = bt ? ones + 1 : 0;
                if (STUFF_EN && ones == 6) begin
                    bits.push_back(0);
                    ev.push_back(0);
                    ones = 0;
                end
            end
        end
        foreach (bits[i]) begin
            if (bits[i] == 0) lvl = 1 - lvl;
            line.push_back(lvl);
        end
        line.push_back(2); line.push_back(2); line.push_back(0);
        ev.push_back(0);   ev.push_back(0);   ev.push_back(3);
        for (int p = 0; p < line.size(); p++) begin
            for (int t = 0; t < CPB; t++) begin
                int   code;
                exp_t e;
                code   = (t == 0) ? (p == 0 ? 0 : line[p-1]) : line[p];
                e.dp   = (code == 0);
                e.dm   = (code == 1);
                e.se   = (t == CPB - 1) && ev[p] == 1;
                e.br   = (t == CPB - 1) && ev[p] == 2;
                e.dn   = (t == CPB - 1) && ev[p] == 3;
                e.busy = 1'b1;
                sb.push_back(e);
            end
        end
        sb.push_back(exp_t'(6'b100000));
    endtask

    task automatic launch();
        @(posedge clk); #1;
        tx_start = 1'b1; start_load = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0; start_load = 1'b0;
        se_cnt = 0; br_cnt = 0; busy_cnt = 0; cyc_no = 0;
        build_exp();
    endtask

    task automatic run_packet(input int repulse);
        bit done;
        launch();
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk); #1;
            tx_start = (c == repulse);
            if (sb.size() == 0) done = 1'b1;
        end
        tx_start = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL packet_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        n_rst = 1'b0; tx_start = 1'b0;
        foreach (pkt[i]) pkt[i] = 8'h00;
        #12;
        chk("reset_dplus", dplus_out, 1);
        chk("reset_dminus", dminus_out, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_pulses", {shift_enable, byte_req, tx_done}, 0);
        @(posedge clk); #1 n_rst = 1'b1;

        // single byte 0x80
        pkt[0] = 8'h80; pkt_len = 1;
        run_packet(-1);
        chk("b80_shift_cnt", se_cnt, 7);
        chk("b80_byte_req_cnt", br_cnt, 0);
        chk("b80_busy_clks", busy_cnt, 11 * CPB);

        // 0xFC then 0xFF: stuffing across the byte boundary
        pkt[0] = 8'hFC; pkt[1] = 8'hFF; pkt_len = 2;
        run_packet(-1);
        chk("fcff_byte_req_cnt", br_cnt, 1);
        chk("fcff_shift_cnt", se_cnt, 14);
        chk("fcff_busy_clks", busy_cnt, ((STUFF_EN ? 18 : 16) + 3) * CPB);

        // 0xFF alone, and mid-packet tx_start re-pulse
        pkt[0] = 8'hFF; pkt_len = 1;
        run_packet(-1);
        chk("ff_busy_clks", busy_cnt, ((STUFF_EN ? 9 : 8) + 3) * CPB);
        pkt[0] = 8'h5A; pkt[1] = 8'h00; pkt_len = 2;
        run_packet(37);
        chk("repulse_shift_cnt", se_cnt, 14);
        chk("repulse_byte_req_cnt", br_cnt, 1);

        // reset during bit 3 of the first byte
        pkt[0] = 8'h3C; pkt[1] = 8'hFF; pkt_len = 2;
        launch();
        repeat (28) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        sb.delete();
        chk("midrst_dplus", dplus_out, 1);
        chk("midrst_dminus", dminus_out, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_pulses", {shift_enable, byte_req, tx_done}, 0);
        repeat (3) @(posedge clk);
        chk("midrst_no_eop", {dplus_out, dminus_out, tx_busy}, 3'b100);
        #1 n_rst = 1'b1;
        pkt[0] = 8'h3C; pkt_len = 1;
        run_packet(-1);
        chk("postrst_shift_cnt", se_cnt, 7);

        // randomized packets, biased toward long runs of ones
        for (int n = 0; n < 10; n++) begin
            pkt_len = $urandom_range(1, 3);
            for (int b = 0; b < pkt_len; b++) begin
                pkt[b] = 8'($urandom);
                if ($urandom_range(0, 1) == 1) pkt[b] = pkt[b] | 8'hF7;
            end
            run_packet($urandom_range(0, 1) == 1 ? int'($urandom_range(5, 60)) : -1);
            chk("rand_byte_req_cnt", br_cnt, pkt_len - 1);
            chk("rand_shift_cnt", se_cnt, 7 * pkt_len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
